dice_cgra_tid_pipe: RTL and testbench
=====================================

DICE_CGRA_TID_PIPE -- requirements
Module: dice_cgra_tid_pipe

Interface
REQ-001 SHALL have parameter NUM_LANES, default 1: thread IDs issued per cycle.
REQ-002 SHALL have parameter NUM_TID, default 512: TID space; TID_WIDTH = $clog2(NUM_TID).
REQ-003 SHALL have parameter MAX_LATENCY, default 32: deepest pipeline; LAT_WIDTH = $clog2(MAX_LATENCY+1).
REQ-004 SHALL have parameter CNT_WIDTH, default $clog2(MAX_LATENCY+1): width of the in-flight counter.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 clr  in  1  synchronous flush.
REQ-008 cfg_load  in  1  request to latch latency.
REQ-009 cfg_latency  in  LAT_WIDTH  requested compute latency, 0..MAX_LATENCY.
REQ-010 in_valid  in  NUM_LANES  per-lane issue valid.
REQ-011 in_tid  in  NUM_LANES*TID_WIDTH  lane i at [i*TID_WIDTH +: TID_WIDTH].
REQ-012 in_ready  out  1  beat accepted when high.
REQ-013 out_valid  out  NUM_LANES  per-lane writeback valid.
REQ-014 out_tid  out  NUM_LANES*TID_WIDTH  writeback TIDs.
REQ-015 out_ready  in  1  writeback sink ready.
REQ-016 inflight  out  CNT_WIDTH  occupied beats.
REQ-017 busy  out  1  inflight != 0.
REQ-018 cfg_err  out  1  sticky illegal-config flag.
REQ-019 cur_latency  out  LAT_WIDTH  active latency.

Function
REQ-020 Beat = one cycle's lanes; beat occupied iff any lane valid; all lanes of a beat move together.
REQ-021 advance = ~|out_valid | out_ready; in_ready SHALL equal advance (combinational).
REQ-022 cur_latency = L >= 1: on advance, stage 0 loads in_valid/in_tid and stages 1..L-1 shift; when not advancing, all stages hold.
REQ-023 With no stalls, a beat accepted at edge t SHALL present on out_valid/out_tid during cycle t+L; each stall cycle adds exactly one cycle.
REQ-024 out_valid/out_tid SHALL be driven by registered stage L-1; stages >= L SHALL be ignored.
REQ-025 L = 0: out_valid = in_valid and out_tid = in_tid (combinational); in_ready = out_ready; inflight stays 0.
REQ-026 out_tid lanes with out_valid low SHALL read 0.
REQ-027 inflight SHALL increment on an accepted occupied input beat, decrement on out handshake (|out_valid & out_ready), and hold on both or neither.
REQ-028 inflight SHALL never exceed L; empty input beats are bubbles, not counted.
REQ-029 cfg_load with inflight == 0, no handshake that cycle, and cfg_latency <= MAX_LATENCY SHALL set cur_latency = cfg_latency at the next edge.
REQ-030 cfg_load otherwise SHALL be ignored and set cfg_err (sticky).
REQ-031 clr SHALL clear all stage valids, inflight and cfg_err at the next edge; the input beat that cycle is dropped; cur_latency is kept.
REQ-032 clr has priority over input acceptance and cfg_load in the same cycle.

Reset
REQ-033 On rst: all stage valids 0, stage TIDs 0, inflight 0, cfg_err 0, cur_latency 1.
REQ-034 Out of reset: out_valid 0, out_tid 0, busy 0, in_ready 1.
REQ-035 rst mid-operation SHALL discard all in-flight beats with no output handshake.

Structure
REQ-036 LAT_WIDTH/CNT_WIDTH helpers and a tid_beat_t struct (valid vector plus TID array) SHALL live in dice_cgra_pkg.
REQ-037 One stage register, dice_tid_pipe_stage (hold/load/clear), SHALL be instantiated MAX_LATENCY times via generate.

Verification
REQ-038 L=3, out_ready=1, in_tid=5 valid at cycle 0 -> out_valid=1, out_tid=5 at cycle 3; inflight 1,1,1 then 0.
REQ-039 L=2, beats 7,8,9 back-to-back, out_ready low cycles 3-4 -> in_ready low cycles 3-4; outputs 7,8,9 in order, none lost or duplicated.
REQ-040 NUM_LANES=4, L=1, in_valid=4'b1010, TIDs 1,2,3,4 -> next cycle out_valid=1010, out_tid lanes 0/2 = 0, lanes 1/3 = 2/4.
REQ-041 Two beats in flight, cfg_load cfg_latency=5 -> cur_latency unchanged, cfg_err=1; after clr -> inflight 0, cfg_err 0; then cfg_load -> cur_latency=5.
REQ-042 L=0, in_tid=11 valid, out_ready=0 -> out_valid=1 same cycle, in_ready=0, inflight stays 0.
REQ-043 rst asserted with 3 beats in flight -> out_valid=0, inflight=0, cur_latency=1 immediately, no handshake observed.

Source files
------------

// File: rtl/dice_cgra_pkg.sv
// Shared sizing helpers and the default-geometry beat type for the TID pipeline.
// Pure declarations: no latency, no flow control.
package dice_cgra_pkg;

    localparam int DEF_NUM_LANES   = 1;
    localparam int DEF_NUM_TID     = 512;
    localparam int DEF_MAX_LATENCY = 32;
    localparam int DEF_TID_WIDTH   = $clog2(DEF_NUM_TID);

    function automatic int lat_width(input int max_latency);
        return $clog2(max_latency + 1);
    endfunction

    function automatic int cnt_width(input int max_latency);
        return $clog2(max_latency + 1);
    endfunction

    // One cycle's worth of lanes: per-lane valid plus the TID carried by each lane.
    typedef struct packed {
        logic [DEF_NUM_LANES-1:0]                    vld;
        logic [DEF_NUM_LANES-1:0][DEF_TID_WIDTH-1:0] tid;
    } tid_beat_t;

endpackage

// File: rtl/dice_tid_pipe_stage.sv
// One pipeline stage register for a whole beat: clear beats load, load beats hold.
// Latency one cycle when loaded; holds its contents whenever load_i is low.
module dice_tid_pipe_stage
    import dice_cgra_pkg::*;
#(
    parameter type beat_t = tid_beat_t
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  clr_i,
    input  logic  load_i,
    input  beat_t beat_i,
    output beat_t beat_o
);

    beat_t beat_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_q <= '0;
        end else if (clr_i) begin
            beat_q <= '0;
        end else if (load_i) begin
            beat_q <= beat_i;
        end
    end

    assign beat_o = beat_q;

endmodule

// File: rtl/dice_cgra_tid_pipe.sv
// Delays issued thread-ID beats by a runtime latency (0..MAX_LATENCY) and tracks occupancy.
// Whole pipe stalls while a writeback beat is presented without out_ready; in_ready mirrors that.
module dice_cgra_tid_pipe
    import dice_cgra_pkg::*;
#(
    parameter int  NUM_LANES   = DEF_NUM_LANES,
    parameter int  NUM_TID     = DEF_NUM_TID,
    parameter int  MAX_LATENCY = DEF_MAX_LATENCY,
    parameter int  CNT_WIDTH   = cnt_width(MAX_LATENCY),
    localparam int TID_WIDTH   = $clog2(NUM_TID),
    localparam int LAT_WIDTH   = lat_width(MAX_LATENCY)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clr,
    input  logic                           cfg_load,
    input  logic [LAT_WIDTH-1:0]           cfg_latency,
    input  logic [NUM_LANES-1:0]           in_valid,
    input  logic [NUM_LANES*TID_WIDTH-1:0] in_tid,
    output logic                           in_ready,
    output logic [NUM_LANES-1:0]           out_valid,
    output logic [NUM_LANES*TID_WIDTH-1:0] out_tid,
    input  logic                           out_ready,
    output logic [CNT_WIDTH-1:0]           inflight,
    output logic                           busy,
    output logic                           cfg_err,
    output logic [LAT_WIDTH-1:0]           cur_latency
);

    typedef struct packed {
        logic [NUM_LANES-1:0]                vld;
        logic [NUM_LANES-1:0][TID_WIDTH-1:0] tid;
    } beat_t;

    beat_t                in_beat;
    beat_t                out_beat;
    beat_t                stage_q [MAX_LATENCY];
    logic [LAT_WIDTH-1:0] cur_lat_q, cur_lat_d;
    logic [CNT_WIDTH-1:0] inflight_q, inflight_d;
    logic                 cfg_err_q, cfg_err_d;
    logic                 lat_zero, advance, out_hs, in_acc, cfg_ok;
    logic                 cnt_inc, cnt_dec;

    assign in_beat.vld = in_valid;
    assign in_beat.tid = in_tid;
    assign lat_zero    = (cur_lat_q == '0);

    always_comb begin
        out_beat = '0;
        if (lat_zero) begin
            out_beat = in_beat;
        end else begin
            for (int k = 0; k < MAX_LATENCY; k++) begin
                if (cur_lat_q == LAT_WIDTH'(k + 1)) begin
                    out_beat = stage_q[k];
                end
            end
        end
    end

    assign out_valid = out_beat.vld;

    always_comb begin
        out_tid = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (out_beat.vld[i]) begin
                out_tid[i*TID_WIDTH +: TID_WIDTH] = out_beat.tid[i];
            end
        end
    end

    assign advance  = ~(|out_valid) | out_ready;
    assign in_ready = lat_zero ? out_ready : advance;
    assign out_hs   = (|out_valid) & out_ready;
    assign in_acc   = in_ready & (|in_valid) & ~clr;

    // A latency change is only safe when nothing is in flight and nothing leaves this cycle.
    assign cfg_ok = cfg_load & ~clr & (inflight_q == '0) & ~out_hs
                  & (cfg_latency <= LAT_WIDTH'(MAX_LATENCY));

    assign cur_lat_d = cfg_ok ? cfg_latency : cur_lat_q;
    assign cnt_inc   = in_acc & (cur_lat_d != '0);
    assign cnt_dec   = out_hs & ~lat_zero;

    always_comb begin
        inflight_d = inflight_q;
        if (clr) begin
            inflight_d = '0;
        end else if (cnt_inc & ~cnt_dec) begin
            inflight_d = inflight_q + CNT_WIDTH'(1);
        end else if (cnt_dec & ~cnt_inc) begin
            inflight_d = inflight_q - CNT_WIDTH'(1);
        end
    end

    assign cfg_err_d = clr ? 1'b0 : (cfg_err_q | (cfg_load & ~cfg_ok));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_lat_q  <= LAT_WIDTH'(1);
            inflight_q <= '0;
            cfg_err_q  <= 1'b0;
        end else begin
            cur_lat_q  <= cur_lat_d;
            inflight_q <= inflight_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    // Stages at or beyond the active latency are held empty so a later latency
    // increase never exposes a stale beat.
    for (genvar k = 0; k < MAX_LATENCY; k++) begin : g_stage
        beat_t stage_d;
        logic  stage_clr;

        if (k == 0) begin : g_first
            assign stage_d = in_beat;
        end else begin : g_rest
            assign stage_d = stage_q[k-1];
        end

        assign stage_clr = clr | (cur_lat_q <= LAT_WIDTH'(k));

        dice_tid_pipe_stage #(
            .beat_t (beat_t)
        ) u_stage (
            .clk    (clk),
            .rst    (rst),
            .clr_i  (stage_clr),
            .load_i (advance),
            .beat_i (stage_d),
            .beat_o (stage_q[k])
        );
    end

    assign inflight    = inflight_q;
    assign busy        = (inflight_q != '0);
    assign cfg_err     = cfg_err_q;
    assign cur_latency = cur_lat_q;

endmodule

// File: tb/tb_dice_cgra_tid_pipe.sv
// Directed bench: expected writeback beats go into a scoreboard queue, a negedge monitor checks them.
module tb_dice_cgra_tid_pipe;

    localparam int NL = 4;
    localparam int NT = 512;
    localparam int ML = 8;
    localparam int TW = 9;
    localparam int LW = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          clr;
    logic          cfg_load;
    logic [LW-1:0] cfg_latency;
    logic [NL-1:0] in_valid;
    logic [NL*TW-1:0] in_tid;
    logic          in_ready;
    logic [NL-1:0] out_valid;
    logic [NL*TW-1:0] out_tid;
    logic          out_ready;
    logic [CW-1:0] inflight;
    logic          busy;
    logic          cfg_err;
    logic [LW-1:0] cur_latency;

    always #5 clk = ~clk;

    dice_cgra_tid_pipe #(
        .NUM_LANES   (NL),
        .NUM_TID     (NT),
        .MAX_LATENCY (ML)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .clr         (clr),
        .cfg_load    (cfg_load),
        .cfg_latency (cfg_latency),
        .in_valid    (in_valid),
        .in_tid      (in_tid),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_tid     (out_tid),
        .out_ready   (out_ready),
        .inflight    (inflight),
        .busy        (busy),
        .cfg_err     (cfg_err),
        .cur_latency (cur_latency)
    );

    typedef struct packed {
        logic [NL-1:0]    vld;
        logic [NL*TW-1:0] tid;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   n;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [NL*TW-1:0] t4(input int a, input int b, input int c, input int d);
        return {TW'(d), TW'(c), TW'(b), TW'(a)};
    endfunction

    task automatic push_exp(input logic [NL-1:0] v, input logic [NL*TW-1:0] t);
        exp_t e;
        e.vld = v;
        e.tid = t;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic set_lat(input int l);
        cfg_load    = 1'b1;
        cfg_latency = LW'(l);
        tick();
        cfg_load    = 1'b0;
    endtask

    // Scoreboard monitor: every writeback handshake must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && (|out_valid) && out_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_extra: got vld=%b tid=%h, expected no beat", out_valid, out_tid);
            end else begin
                e = exp_q.pop_front();
                chk("sb_vld", 64'(out_valid), 64'(e.vld));
                chk("sb_tid", 64'(out_tid), 64'(e.tid));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; clr = 1'b0; cfg_load = 1'b0; cfg_latency = '0;
        in_valid = '0; in_tid = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        smp();
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_out_tid", 64'(out_tid), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_in_ready", 64'(in_ready), 1);
        chk("rst_inflight", 64'(inflight), 0);
        chk("rst_cur_lat", 64'(cur_latency), 1);
        chk("rst_cfg_err", 64'(cfg_err), 0);

        // L=1, four lanes, sparse valid: invalid lanes read zero
        tick();
        in_valid = 4'b1010; in_tid = t4(1, 2, 3, 4);
        push_exp(4'b1010, t4(0, 2, 0, 4));
        tick();
        in_valid = '0; in_tid = '0;
        smp();
        chk("l1_vld", 64'(out_valid), 64'(4'b1010));
        chk("l1_tid", 64'(out_tid), 64'(t4(0, 2, 0, 4)));
        chk("l1_inflight", 64'(inflight), 1);
        tick(); smp();
        chk("l1_drain", 64'(inflight), 0);

        // L=3 single beat latency and occupancy
        tick(); set_lat(3);
        chk("l3_cfg", 64'(cur_latency), 3);
        in_valid = 4'b0001; in_tid = t4(5, 0, 0, 0);
        push_exp(4'b0001, t4(5, 0, 0, 0));
        tick();
        in_valid = '0; in_tid = '0;
        smp();
        chk("l3_c1_vld", 64'(out_valid), 0);
        chk("l3_c1_infl", 64'(inflight), 1);
        tick(); smp();
        chk("l3_c2_vld", 64'(out_valid), 0);
        chk("l3_c2_infl", 64'(inflight), 1);
        tick(); smp();
        chk("l3_c3_vld", 64'(out_valid), 1);
        chk("l3_c3_tid", 64'(out_tid), 64'(t4(5, 0, 0, 0)));
        chk("l3_c3_infl", 64'(inflight), 1);
        chk("l3_c3_busy", 64'(busy), 1);
        tick(); smp();
        chk("l3_c4_vld", 64'(out_valid), 0);
        chk("l3_c4_infl", 64'(inflight), 0);

        // L=2 back-to-back with a two-cycle writeback stall
        tick(); set_lat(2);
        for (int i = 0; i < 3; i++) begin
            in_valid = 4'b0001; in_tid = t4(7 + i, 0, 0, 0);
            push_exp(4'b0001, t4(7 + i, 0, 0, 0));
            tick();
        end
        in_valid = '0; in_tid = '0; out_ready = 1'b0;
        smp();
        chk("stall_c3_rdy", 64'(in_ready), 0);
        tick(); smp();
        chk("stall_c4_rdy", 64'(in_ready), 0);
        chk("stall_c4_infl", 64'(inflight), 2);
        chk("stall_c4_tid", 64'(out_tid), 64'(t4(8, 0, 0, 0)));
        tick(); out_ready = 1'b1;
        smp();
        chk("stall_c5_rdy", 64'(in_ready), 1);
        tick(); tick(); smp();
        chk("stall_drain", 64'(inflight), 0);
        chk("stall_sb_empty", 64'(exp_q.size()), 0);

        // Config rejected with beats in flight, flushed by clr, then accepted
        tick(); set_lat(3);
        out_ready = 1'b0;
        in_valid = 4'b0001; in_tid = t4(20, 0, 0, 0);
        tick();
        in_tid = t4(21, 0, 0, 0);
        tick();
        in_valid = '0; in_tid = '0;
        cfg_load = 1'b1; cfg_latency = 4'd5;
        tick();
        cfg_load = 1'b0;
        smp();
        chk("busy_cfg_lat", 64'(cur_latency), 3);
        chk("busy_cfg_err", 64'(cfg_err), 1);
        chk("busy_cfg_infl", 64'(inflight), 2);
        tick(); clr = 1'b1;
        tick(); clr = 1'b0;
        smp();
        chk("clr_infl", 64'(inflight), 0);
        chk("clr_err", 64'(cfg_err), 0);
        chk("clr_vld", 64'(out_valid), 0);
        chk("clr_keep_lat", 64'(cur_latency), 3);
        tick(); out_ready = 1'b1; set_lat(5);
        smp();
        chk("cfg5_lat", 64'(cur_latency), 5);
        chk("cfg5_err", 64'(cfg_err), 0);

        // Out-of-range latency, then clr beating a same-cycle cfg_load
        tick(); set_lat(9);
        smp();
        chk("over_lat", 64'(cur_latency), 5);
        chk("over_err", 64'(cfg_err), 1);
        tick(); clr = 1'b1; cfg_load = 1'b1; cfg_latency = 4'd8;
        tick(); clr = 1'b0; cfg_load = 1'b0;
        smp();
        chk("clrprio_lat", 64'(cur_latency), 5);
        chk("clrprio_err", 64'(cfg_err), 0);

        // Maximum latency
        tick(); set_lat(8);
        chk("l8_cfg", 64'(cur_latency), 8);
        in_valid = 4'b0100; in_tid = t4(0, 0, 30, 0);
        push_exp(4'b0100, t4(0, 0, 30, 0));
        tick();
        in_valid = '0; in_tid = '0;
        n = 1;
        smp();
        while (out_valid == '0 && n < 20) begin
            tick(); smp();
            n++;
        end
        chk("l8_latency", 64'(n), 8);
        tick(); smp();
        chk("l8_drain", 64'(inflight), 0);

        // L=0 combinational passthrough
        tick(); set_lat(0);
        out_ready = 1'b0; in_valid = 4'b0001; in_tid = t4(11, 0, 0, 0);
        smp();
        chk("l0_vld", 64'(out_valid), 1);
        chk("l0_tid", 64'(out_tid), 64'(t4(11, 0, 0, 0)));
        chk("l0_rdy", 64'(in_ready), 0);
        chk("l0_infl", 64'(inflight), 0);
        tick();
        out_ready = 1'b1;
        push_exp(4'b0001, t4(11, 0, 0, 0));
        smp();
        chk("l0_rdy_hi", 64'(in_ready), 1);
        tick();
        in_valid = '0; in_tid = '0;
        smp();
        chk("l0_infl_after", 64'(inflight), 0);

        // Reset mid-flight discards everything
        tick(); set_lat(3);
        for (int i = 0; i < 3; i++) begin
            in_valid = 4'b0001; in_tid = t4(40 + i, 0, 0, 0);
            tick();
        end
        in_valid = '0; in_tid = '0; out_ready = 1'b0;
        smp();
        chk("prerst_infl", 64'(inflight), 3);
        chk("prerst_vld", 64'(out_valid), 1);
        #1 rst = 1'b1;
        #1;
        chk("midrst_vld", 64'(out_valid), 0);
        chk("midrst_infl", 64'(inflight), 0);
        chk("midrst_lat", 64'(cur_latency), 1);
        chk("midrst_busy", 64'(busy), 0);
        tick();
        rst = 1'b0; out_ready = 1'b1;
        repeat (4) tick();
        smp();
        chk("final_vld", 64'(out_valid), 0);
        chk("final_sb_empty", 64'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
